signature_accumulator: RTL and testbench

SIGNATURE_ACCUMULATOR -- requirements
Module: signature_accumulator

---
 rtl/signature_accumulator_pkg.sv | 19 +
 rtl/signature_accumulator_if.sv | 33 +++
 rtl/signature_accumulator_scrambler.sv | 14 +
 rtl/signature_accumulator.sv | 97 +++++++++
 tb/tb_signature_accumulator.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/signature_accumulator_pkg.sv
// Shared types and helpers for the signature accumulator: FSM state encoding
// and a width-generic left-rotate.
package signature_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Rotates the low w bits of v left by r; bits above w must be zero on entry.
  function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned w,
                                       input int unsigned r);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((v << r) | (v >> (w - r))) & mask;
  endfunction

endpackage

// File: rtl/signature_accumulator_if.sv
// Control/observation bundle of the signature accumulator; the block is the
// slave, whoever drives runs and golden values is the master.
interface signature_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8,
  parameter int N_CH   = 4
);
  logic                     start;
  logic                     abort;
  logic                     free_run;
  logic [DATA_W-1:0]        seed;
  logic [N_CH*DATA_W-1:0]   ch_data;
  logic [ACC_W-1:0]         expected;
  logic                     snap_req;
  logic [CNT_W-1:0]         stimulus;
  logic [ACC_W-1:0]         signature;
  logic [ACC_W-1:0]         snap_sig;
  logic                     snap_valid;
  logic                     busy;
  logic                     done;
  logic                     match;

  modport master (
    output start, abort, free_run, seed, ch_data, expected, snap_req,
    input  stimulus, signature, snap_sig, snap_valid, busy, done, match
  );

  modport slave (
    input  start, abort, free_run, seed, ch_data, expected, snap_req,
    output stimulus, signature, snap_sig, snap_valid, busy, done, match
  );
endinterface

// File: rtl/signature_accumulator_scrambler.sv
// Folds the seed and every observation channel together with XOR.
module sig_scrambler #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4
) (
  input  logic [DATA_W-1:0]      seed_i,
  input  logic [N_CH*DATA_W-1:0] ch_data_i,
  output logic [DATA_W-1:0]      scrambled_o
);
  always_comb begin
    scrambled_o = seed_i;
    for (int c = 0; c < N_CH; c++) scrambled_o ^= ch_data_i[c*DATA_W +: DATA_W];
  end
endmodule

// File: rtl/signature_accumulator.sv
// Counter-driven signature accumulator: each RUN cycle adds the scrambled
// observation into the low byte of the signature and rotates it left.
module signature_accumulator
  import signature_accumulator_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8,
  parameter int N_CH   = 4,
  parameter int ROT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  signature_accumulator_if.slave  bus
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stim_q, stim_d;
  logic [ACC_W-1:0]   sig_q, sig_d, snap_q, snap_d, upd;
  logic               snap_vld_q, snap_vld_d, done_q, done_d, match_q, match_d;
  logic               fr_q, fr_d;
  logic [DATA_W-1:0]  scrambled, sum;

  sig_scrambler #(.DATA_W(DATA_W), .N_CH(N_CH)) u_scr (
    .seed_i      (bus.seed),
    .ch_data_i   (bus.ch_data),
    .scrambled_o (scrambled)
  );

  // Carry out of the low field is dropped; the upper field passes untouched.
  assign sum = sig_q[DATA_W-1:0] + scrambled;
  assign upd = ACC_W'(rotl(64'({sig_q[ACC_W-1:DATA_W], sum}), ACC_W, ROT));

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    sig_d      = sig_q;
    fr_d       = fr_q;
    done_d     = 1'b0;
    match_d    = match_q;
    snap_d     = bus.snap_req ? sig_q : snap_q;
    snap_vld_d = bus.snap_req;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        stim_d  = '0;
        sig_d   = '0;
        fr_d    = bus.free_run;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!(&stim_q)) begin
          sig_d  = upd;
          stim_d = stim_q + CNT_W'(1);
        end else begin
          // End of pass: signature holds; free-run wraps, one-shot finishes.
          done_d  = 1'b1;
          match_d = (sig_q == bus.expected);
          if (fr_q) stim_d = '0;
          else      state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      stim_q     <= '0;
      sig_q      <= '0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      fr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      sig_q      <= sig_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
      done_q     <= done_d;
      match_q    <= match_d;
      fr_q       <= fr_d;
    end
  end

  assign bus.stimulus   = stim_q;
  assign bus.signature  = sig_q;
  assign bus.snap_sig   = snap_q;
  assign bus.snap_valid = snap_vld_q;
  assign bus.busy       = (state_q == ST_RUN);
  assign bus.done       = done_q;
  assign bus.match      = match_q;
endmodule

// File: tb/tb_signature_accumulator.sv
// Directed and randomized checks of the signature accumulator against an
// arithmetic reference model; a 2-bit-counter instance plus a default one.
module tb_signature_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  signature_accumulator_if #(.CNT_W(2)) ifs ();
  signature_accumulator_if             ifl ();

  signature_accumulator #(.CNT_W(2)) u_small (.clk(clk), .reset(rst_n), .bus(ifs));
  signature_accumulator              u_large (.clk(clk), .reset(rst_n), .bus(ifl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: XOR of seed and all byte channels.
  function automatic logic [7:0] m_scr(input logic [7:0] sd, input logic [31:0] ch);
    logic [7:0] r;
    r = sd;
    for (int c = 0; c < 4; c++) r ^= ch[8*c +: 8];
    return r;
  endfunction

  // Reference: low byte gets (low + x) mod 256, then 16-bit rotate left by one.
  function automatic logic [15:0] m_step(input logic [15:0] s, input logic [7:0] x);
    int unsigned v;
    v = (int'(s) / 256) * 256 + (int'(s[7:0]) + int'(x)) % 256;
    v = v * 2;
    if (v >= 65536) v = v - 65536 + 1;
    return 16'(v);
  endfunction

  initial begin
    logic [15:0] ms, prev, golden;
    int          mstim, ndone;
    logic        expdone, mmatch, r;
    logic [7:0]  rseed;
    logic [31:0] chs [255];

    {ifs.start, ifs.abort, ifs.free_run, ifs.snap_req} = '0;
    {ifl.start, ifl.abort, ifl.free_run, ifl.snap_req} = '0;
    ifs.seed = 8'h01; ifs.ch_data = '0; ifs.expected = 16'h000E;
    ifl.seed = 8'h01; ifl.ch_data = '0; ifl.expected = '0;
    tick(); tick();
    chk("rst_stim",  32'(ifs.stimulus), 0);
    chk("rst_sig",   32'(ifs.signature), 0);
    chk("rst_snap",  32'(ifs.snap_sig), 0);
    chk("rst_flags", {ifs.busy, ifs.done, ifs.snap_valid, ifs.match}, 0);
    chk("rst_l",     {ifl.busy, ifl.done, ifl.match, 8'(ifl.stimulus)}, 0);
    rst_n = 1'b1;
    tick();

    // One-shot, seed 01: 0002, 0006, 000E; snapshot taken while signature=0006.
    ifs.start = 1'b1; tick(); ifs.start = 1'b0;
    chk("os_busy", 32'(ifs.busy), 1);
    chk("os_s0", 32'(ifs.signature), 0);
    tick(); chk("os_s1", 32'(ifs.signature), 32'h0002);
    tick(); chk("os_s2", 32'(ifs.signature), 32'h0006);
    ifs.snap_req = 1'b1;
    tick(); ifs.snap_req = 1'b0;
    chk("os_s3", 32'(ifs.signature), 32'h000E);
    chk("snap_sig", 32'(ifs.snap_sig), 32'h0006);
    chk("snap_vld", 32'(ifs.snap_valid), 1);
    tick();
    chk("snap_vld_off", 32'(ifs.snap_valid), 0);
    chk("os_done", 32'(ifs.done), 1);
    chk("os_match", 32'(ifs.match), 1);
    chk("os_hold", {16'(ifs.signature), 8'(ifs.stimulus)}, {16'h000E, 8'd3});
    tick();
    chk("os_done_off", {ifs.done, ifs.busy}, 0);
    chk("os_idle_hold", 32'(ifs.signature), 32'h000E);
    tick();
    chk("os_done_once", 32'(ifs.done), 0);

    // One-shot, seed FF: carries out of the low byte are dropped.
    ifs.seed = 8'hFF; ifs.expected = 16'h0000;
    ifs.start = 1'b1; tick(); ifs.start = 1'b0;
    tick(); chk("ff_s1", 32'(ifs.signature), 32'h01FE);
    tick(); chk("ff_s2", 32'(ifs.signature), 32'h03FA);
    tick(); chk("ff_s3", 32'(ifs.signature), 32'h07F2);
    tick();
    chk("ff_done", 32'(ifs.done), 1);
    chk("ff_match", 32'(ifs.match), 0);
    tick();

    // Free-run, seed 01: stimulus wraps every 4 cycles with a done pulse.
    ifs.seed = 8'h01; ifs.expected = 16'h000E; ifs.free_run = 1'b1;
    ifs.start = 1'b1; tick(); ifs.start = 1'b0; ifs.free_run = 1'b0;
    ms = 0; mstim = 0; ndone = 0; mmatch = 1'b0;
    chk("fr_stim0", 32'(ifs.stimulus), 0);
    for (int k = 1; k <= 8; k++) begin
      if (mstim == 3) begin
        mstim = 0; expdone = 1'b1; mmatch = (ms == 16'h000E);
      end else begin
        ms = m_step(ms, m_scr(8'h01, 32'h0)); mstim++; expdone = 1'b0;
      end
      tick();
      if (ifs.done) ndone++;
      chk("fr_stim", 32'(ifs.stimulus), 32'(mstim));
      chk("fr_sig", 32'(ifs.signature), 32'(ms));
      chk("fr_done", 32'(ifs.done), 32'(expdone));
      chk("fr_match", 32'(ifs.match), 32'(mmatch));
    end
    chk("fr_ndone", 32'(ndone), 2);
    chk("fr_busy", 32'(ifs.busy), 1);
    ifs.abort = 1'b1; tick(); ifs.abort = 1'b0;
    chk("fr_abort", {ifs.busy, ifs.done, 16'(ifs.signature)}, {2'b00, ms});

    // Reset during RUN at stimulus 5 discards the pass.
    ifl.start = 1'b1; tick(); ifl.start = 1'b0;
    repeat (5) tick();
    chk("mr_stim5", 32'(ifl.stimulus), 5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mr_zero", {16'(ifl.signature), 8'(ifl.stimulus)}, 0);
    chk("mr_flags", {ifl.busy, ifl.done, ifl.match, ifl.snap_valid, |ifl.snap_sig}, 0);
    ndone = 0;
    repeat (4) begin tick(); if (ifl.done || ifl.busy) ndone++; end
    chk("mr_no_done", 32'(ndone), 0);

    // Start during RUN is ignored; abort at stimulus 3 holds everything.
    ifl.seed = 8'h5A; ifl.ch_data = 32'h0102_0304;
    ifl.start = 1'b1; tick(); ifl.start = 1'b0;
    ms = 0;
    tick(); ms = m_step(ms, m_scr(8'h5A, 32'h0102_0304));
    ifl.start = 1'b1; tick(); ifl.start = 1'b0; ms = m_step(ms, m_scr(8'h5A, 32'h0102_0304));
    chk("ign_start", 32'(ifl.stimulus), 2);
    tick(); ms = m_step(ms, m_scr(8'h5A, 32'h0102_0304));
    chk("ab_stim3", 32'(ifl.stimulus), 3);
    ifl.abort = 1'b1; tick(); ifl.abort = 1'b0;
    chk("ab_idle", {ifl.busy, ifl.done}, 0);
    chk("ab_hold", {16'(ifl.signature), 8'(ifl.stimulus)}, {ms, 8'd3});
    tick();
    chk("ab_hold2", {16'(ifl.signature), 8'(ifl.stimulus)}, {ms, 8'd3});

    // Randomized full one-shot pass with per-cycle channels and snapshots.
    rseed = 8'($urandom);
    golden = 0;
    for (int i = 0; i < 255; i++) begin
      chs[i] = $urandom;
      golden = m_step(golden, m_scr(rseed, chs[i]));
    end
    ifl.seed = rseed; ifl.expected = golden;
    ifl.start = 1'b1; tick(); ifl.start = 1'b0;
    ms = 0;
    for (int i = 0; i < 255; i++) begin
      ifl.ch_data = chs[i];
      r = ($urandom_range(0, 3) == 0);
      ifl.snap_req = r;
      prev = ms;
      ms = m_step(ms, m_scr(rseed, chs[i]));
      tick();
      chk("rnd_sig", 32'(ifl.signature), 32'(ms));
      chk("rnd_stim", 32'(ifl.stimulus), 32'(i + 1));
      chk("rnd_snap_vld", 32'(ifl.snap_valid), 32'(r));
      if (r) chk("rnd_snap_sig", 32'(ifl.snap_sig), 32'(prev));
      chk("rnd_no_done", 32'(ifl.done), 0);
    end
    ifl.snap_req = 1'b0;
    tick();
    chk("rnd_done", {ifl.done, ifl.match, ifl.busy}, 3'b110);
    chk("rnd_final", 32'(ifl.signature), 32'(golden));
    tick();
    chk("rnd_done_off", 32'(ifl.done), 0);
    chk("rnd_match_hold", 32'(ifl.match), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
